// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with three combinational read ports, three write ports and 64-bit cycle/instret counters
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr1,
    input  logic [11:0] csr_addr2,
    input  logic [11:0] csr_addr3,
    input  logic        csr_we1,
    input  logic        csr_we2,
    input  logic        csr_we3,
    input  logic [31:0] csr_wd1,
    input  logic [31:0] csr_wd2,
    input  logic [31:0] csr_wd3,
    input  logic        instret_inc,
    output logic [31:0] csr_rd1,
    output logic [31:0] csr_rd2,
    output logic [31:0] csr_rd3
);
    localparam logic [11:0] WA [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                        12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
    logic [11:0] addr [3];
    logic        we [3];
    logic [31:0] wd [3];
    logic [31:0] rd [3];
    logic [11:0] hit;
    logic [31:0] wdat [12];
    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [63:0] mcycle_q, minstret_q;
    assign addr = '{csr_addr1, csr_addr2, csr_addr3};
    assign we   = '{csr_we1, csr_we2, csr_we3};
    assign wd   = '{csr_wd1, csr_wd2, csr_wd3};
    assign csr_rd1 = rd[0];
    assign csr_rd2 = rd[1];
    assign csr_rd3 = rd[2];
    // later ports overwrite earlier ones, so port 3 wins a same-register conflict
    always_comb begin
        for (int r = 0; r < 12; r++) begin
            hit[r]  = 1'b0;
            wdat[r] = '0;
            for (int p = 0; p < 3; p++)
                if (we[p] && addr[p] == WA[r]) begin
                    hit[r]  = 1'b1;
                    wdat[r] = wd[p];
                end
        end
    end
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd[p] = '0;
            case (addr[p])
                12'h300:          rd[p] = mstatus_q | 32'h0000_1800;
                12'h301:          rd[p] = MISA_VALUE;
                12'h304:          rd[p] = mie_q;
                12'h305:          rd[p] = mtvec_q;
                12'h340:          rd[p] = mscratch_q;
                12'h341:          rd[p] = mepc_q;
                12'h342:          rd[p] = mcause_q;
                12'h343:          rd[p] = mtval_q;
                12'h344:          rd[p] = mip_q;
                12'hB00, 12'hC00: rd[p] = mcycle_q[31:0];
                12'hB80, 12'hC80: rd[p] = mcycle_q[63:32];
                12'hB02, 12'hC02: rd[p] = minstret_q[31:0];
                12'hB82, 12'hC82: rd[p] = minstret_q[63:32];
                12'hF14:          rd[p] = HART_ID;
                default:          rd[p] = '0;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (hit[0]) mstatus_q  <= wdat[0] & 32'h0000_0088;
            if (hit[1]) mie_q      <= wdat[1];
            if (hit[2]) mtvec_q    <= wdat[2] & ~32'h3;
            if (hit[3]) mscratch_q <= wdat[3];
            if (hit[4]) mepc_q     <= wdat[4] & ~32'h3;
            if (hit[5]) mcause_q   <= wdat[5];
            if (hit[6]) mtval_q    <= wdat[6];
            if (hit[7]) mip_q      <= wdat[7];
            mcycle_q   <= (hit[8] || hit[9])
                ? {hit[9] ? wdat[9] : mcycle_q[63:32], hit[8] ? wdat[8] : mcycle_q[31:0]}
                : mcycle_q + 64'd1;
            minstret_q <= (hit[10] || hit[11])
                ? {hit[11] ? wdat[11] : minstret_q[63:32], hit[10] ? wdat[10] : minstret_q[31:0]}
                : minstret_q + {63'd0, instret_inc};
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus queues expected read values; a negedge monitor pops and compares them
module tb_csr_file;
    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instret_inc = 1'b0;
    logic [11:0] a [3];
    logic        we [3];
    logic [31:0] wd [3];
    logic [31:0] rd1, rd2, rd3;
    exp_t        q [$];
    exp_t        e;
    logic [31:0] got;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    csr_file #(.MTVEC_RESET(32'h8000_0103)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_addr1(a[0]), .csr_addr2(a[1]), .csr_addr3(a[2]),
        .csr_we1(we[0]), .csr_we2(we[1]), .csr_we3(we[2]),
        .csr_wd1(wd[0]), .csr_wd2(wd[1]), .csr_wd3(wd[2]),
        .instret_inc(instret_inc),
        .csr_rd1(rd1), .csr_rd2(rd2), .csr_rd3(rd3)
    );

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            got = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : rd3;
            n_checks++;
            if (got === e.exp) n_pass++;
            else $display("FAIL %s: port%0d read %h, expected %h", e.name, e.port + 1, got, e.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            a[i]  = 12'h000;
            wd[i] = 32'h0;
        end
    endtask

    task automatic wr(input int p, input logic [11:0] ad, input logic [31:0] d);
        we[p] = 1'b1;
        a[p]  = ad;
        wd[p] = d;
    endtask

    task automatic rd(input int p, input logic [11:0] ad, input string n, input logic [31:0] x);
        a[p] = ad;
        q.push_back('{n, p, x});
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            a[i]  = 12'h000;
            wd[i] = 32'h0;
        end
        step();
        rd(0, 12'h305, "rst_mtvec", 32'h8000_0100);
        rd(1, 12'h300, "rst_mstatus", 32'h0000_1800);
        rd(2, 12'hF14, "rst_mhartid", 32'h0);
        step();
        rd(0, 12'h301, "rst_misa", 32'h4000_0100);
        rd(1, 12'hB00, "rst_mcycle", 32'h0);
        rd(2, 12'hB02, "rst_minstret", 32'h0);
        step();
        rst_n = 1'b1;
        rd(0, 12'hB00, "mcycle_release", 32'h0);
        step();
        rd(0, 12'hB00, "mcycle_first_edge", 32'h1);
        rd(1, 12'h305, "mtvec_after_release", 32'h8000_0100);
        // distinct registers written on two ports while the third reads
        step();
        wr(0, 12'h342, 32'd11);
        wr(1, 12'h341, 32'h0000_0203);
        rd(2, 12'h305, "rd3_during_writes", 32'h8000_0100);
        step();
        rd(0, 12'h342, "mcause", 32'd11);
        rd(1, 12'h341, "mepc_aligned", 32'h0000_0200);
        rd(2, 12'h305, "mtvec_untouched", 32'h8000_0100);
        // three-way conflict on mscratch
        step();
        wr(0, 12'h340, 32'd1);
        wr(1, 12'h340, 32'd2);
        wr(2, 12'h340, 32'd3);
        rd(0, 12'h340, "mscratch_old_in_wr_cycle", 32'h0);
        step();
        rd(0, 12'h340, "mscratch_port3_wins", 32'd3);
        // masks and read-only registers
        step();
        wr(0, 12'h300, 32'hFFFF_FFFF);
        wr(1, 12'h305, 32'h1234_5677);
        wr(2, 12'h301, 32'h0);
        step();
        rd(0, 12'h300, "mstatus_mask", 32'h0000_1888);
        rd(1, 12'h305, "mtvec_mask", 32'h1234_5674);
        rd(2, 12'h301, "misa_readonly", 32'h4000_0100);
        step();
        wr(0, 12'h123, 32'hDEAD_BEEF);
        wr(1, 12'h300, 32'h0000_0008);
        rd(1, 12'h300, "mstatus_rmw_old", 32'h0000_1888);
        rd(2, 12'h123, "unimpl_read", 32'h0);
        step();
        rd(0, 12'h123, "unimpl_write_ignored", 32'h0);
        rd(2, 12'h300, "mstatus_mie_only", 32'h0000_1808);
        // 64-bit cycle counter load and wrap
        step();
        wr(0, 12'hB00, 32'hFFFF_FFFF);
        wr(1, 12'hB80, 32'h0000_0005);
        step();
        rd(0, 12'hB00, "mcycle_loaded_lo", 32'hFFFF_FFFF);
        rd(1, 12'hB80, "mcycleh_loaded", 32'h5);
        rd(2, 12'hC80, "cycleh_shadow", 32'h5);
        step();
        rd(0, 12'hB00, "mcycle_wrap_lo", 32'h0);
        rd(1, 12'hB80, "mcycleh_carry", 32'h6);
        rd(2, 12'hC80, "cycleh_shadow_carry", 32'h6);
        // minstret: 4 increments, load 100 (no increment), 5 increments
        for (int c = 1; c <= 10; c++) begin
            step();
            instret_inc = 1'b1;
            if (c == 5) wr(0, 12'hB02, 32'd100);
            if (c == 7) wr(1, 12'hC02, 32'h5555_5555);
        end
        step();
        instret_inc = 1'b0;
        rd(0, 12'hB02, "minstret", 32'd105);
        rd(1, 12'hC02, "instret_shadow", 32'd105);
        rd(2, 12'hB82, "minstreth", 32'h0);
        // reset asserted in the middle of a write cycle
        step();
        wr(0, 12'h304, 32'h0000_00AA);
        step();
        rd(1, 12'h304, "mie_written", 32'h0000_00AA);
        step();
        wr(0, 12'h304, 32'hFFFF_FFFF);
        #1;
        rst_n = 1'b0;
        rd(1, 12'h304, "mie_async_reset", 32'h0);
        rd(2, 12'hB00, "mcycle_async_reset", 32'h0);
        step();
        rst_n = 1'b1;
        rd(0, 12'hB02, "minstret_restart", 32'h0);
        rd(1, 12'h304, "mie_after_release", 32'h0);
        rd(2, 12'hB00, "mcycle_restart", 32'h0);
        step();
        rd(2, 12'hB00, "mcycle_restart_first_edge", 32'h1);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
